data_memory_responder: RTL

- Main-memory model answering the data cache's line-fill requests and its write-through word writes.
- Sits between the data cache and backing storage.
- Reads return a full 512-bit line (16 words) after a fixed wait plus a 16-cycle word burst.
- Word writes are accepted every cycle, in every state.

---
 rtl/data_memory_responder.sv | 120 ++++++++++++
 1 files changed

// File: rtl/data_memory_responder.sv
// Main-memory model: fills data-cache lines after a fixed wait plus a 16-word burst,
// and accepts write-through word writes every cycle. Optional macro DMEM_WRITE_ACK_EN adds memoryWriteAck.
module data_memory_responder #(
  parameter int MEM_WORDS    = 16384,
  parameter int READ_LATENCY = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         memoryReadReq,
  input  logic [31:0]  memoryReadAddr,
  output logic [511:0] memoryReadData,
  output logic         memoryReadEnable,
  input  logic         memoryWritePulse,
  input  logic [31:0]  memoryWriteAddr,
  input  logic [31:0]  memoryWriteData
`ifdef DMEM_WRITE_ACK_EN
  ,
  output logic         memoryWriteAck
`endif
);

  localparam int ADDR_W = $clog2(MEM_WORDS);
  localparam int WAIT_W = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(READ_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, BURST, RESPOND} state_t;

  state_t            state;
  logic [25:0]       line_addr;
  logic [WAIT_W-1:0] wait_cnt;
  logic [3:0]        word_cnt;
  logic [31:0]       storage [MEM_WORDS];

  logic [29:0]       read_full;
  logic [ADDR_W-1:0] read_idx;
  logic [ADDR_W-1:0] write_idx;
  logic [31:0]       read_word;
  logic              fwd_hit;
  logic [3:0]        fwd_slot;
  logic              unused_bits;

  // Line base times 16 plus word offset, folded onto the storage depth (upper bits alias).
  assign read_full = {line_addr, word_cnt};
  assign read_idx  = read_full[ADDR_W-1:0];
  assign write_idx = memoryWriteAddr[ADDR_W+1:2];
  assign read_word = storage[read_idx];
  assign fwd_hit   = memoryWritePulse && (state == BURST) &&
                     (write_idx[ADDR_W-1:4] == read_idx[ADDR_W-1:4]);
  assign fwd_slot  = write_idx[3:0];

  assign unused_bits = ^{memoryReadAddr[5:0], memoryWriteAddr[1:0],
                         memoryWriteAddr[31:ADDR_W+2], read_full[29:ADDR_W]};

  // Storage is never cleared by reset; writes land in every state.
  always_ff @(posedge clk) begin
    if (memoryWritePulse) begin
      storage[write_idx] <= memoryWriteData;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      memoryReadEnable <= 1'b0;
      memoryReadData   <= '0;
      line_addr        <= '0;
      wait_cnt         <= '0;
      word_cnt         <= '0;
    end else begin
      memoryReadEnable <= 1'b0;
      case (state)
        IDLE: begin
          if (memoryReadReq) begin
            line_addr <= memoryReadAddr[31:6];
            wait_cnt  <= WAIT_LOAD;
            word_cnt  <= 4'd0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            state <= BURST;
          end else begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end
        end
        BURST: begin
          // The forwarded write is assigned last so it wins when it targets the slot being captured.
          memoryReadData[{word_cnt, 5'b0} +: 32] <= read_word;
          if (fwd_hit) begin
            memoryReadData[{fwd_slot, 5'b0} +: 32] <= memoryWriteData;
          end
          if (word_cnt == 4'd15) begin
            state            <= RESPOND;
            memoryReadEnable <= 1'b1;
          end else begin
            word_cnt <= word_cnt + 4'd1;
          end
        end
        RESPOND: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef DMEM_WRITE_ACK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      memoryWriteAck <= 1'b0;
    end else begin
      memoryWriteAck <= memoryWritePulse;
    end
  end
`endif

endmodule
